// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the handshaked memory stage:
// RV32I load/store funct3 encodings, FSM state, byte-lane patterns.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Lane patterns before shifting by the byte offset
    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

endpackage

// File: rtl/mem_stage_hs_if.sv
// Data-memory request/ack bus between the memory stage (master) and the
// memory (slave). The master also publishes its FSM state for observation.
interface mem_stage_hs_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0]     addr;
    logic                  mreq;
    logic                  write;
    logic [3:0]            byte_en;
    logic [31:0]           wr_data;
    logic                  ack;
    logic [31:0]           rd_data;
    mem_stage_pkg::state_e state;

    modport master (
        output addr, mreq, write, byte_en, wr_data, state,
        input  ack, rd_data
    );

    modport slave (
        input  addr, mreq, write, byte_en, wr_data, state,
        output ack, rd_data
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: legality/alignment of a new access, its byte
// enables and replicated store data, and extraction/extension of a load word.
module mem_lane_align
    import mem_stage_pkg::*;
(
    // request side (decoded from the incoming instruction)
    input  logic [2:0]  req_funct3,
    input  logic        req_is_write,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic        req_legal,
    output logic        req_aligned,
    output logic [3:0]  req_be,
    output logic [31:0] req_wr_data,
    // response side (uses the funct3/offset latched at acceptance)
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_off,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] rsp_load_data
);
    logic [31:0] shifted;

    // Legality, alignment, lane enables and store replication per size
    always_comb begin
        req_legal   = 1'b0;
        req_aligned = 1'b0;
        req_be      = 4'b0000;
        req_wr_data = 32'h0;
        case (req_funct3)
            F3_B: begin
                req_legal   = 1'b1;
                req_aligned = 1'b1;
                req_be      = BE_B << req_off;
                req_wr_data = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                req_legal   = 1'b1;
                req_aligned = ~req_off[0];
                req_be      = BE_H << req_off;
                req_wr_data = {2{req_wdata[15:0]}};
            end
            F3_W: begin
                req_legal   = 1'b1;
                req_aligned = (req_off == 2'b00);
                req_be      = BE_W;
                req_wr_data = req_wdata;
            end
            // unsigned variants exist only for loads
            F3_BU: begin
                req_legal   = ~req_is_write;
                req_aligned = 1'b1;
                req_be      = BE_B << req_off;
            end
            F3_HU: begin
                req_legal   = ~req_is_write;
                req_aligned = ~req_off[0];
                req_be      = BE_H << req_off;
            end
            default: begin
                req_legal = 1'b0;
            end
        endcase
    end

    assign shifted = rsp_rdata >> {rsp_off, 3'b000};

    // Load extraction with sign or zero extension
    always_comb begin
        rsp_load_data = 32'h0;
        case (rsp_funct3)
            F3_B:    rsp_load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rsp_load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rsp_load_data = shifted;
            F3_BU:   rsp_load_data = {24'h0, shifted[7:0]};
            F3_HU:   rsp_load_data = {16'h0, shifted[15:0]};
            default: rsp_load_data = 32'h0;
        endcase
    end
endmodule

// File: rtl/mem_stage_hs.sv
// Multi-cycle memory stage: accepts one load/store, issues a registered
// request on the memory bus and holds the pipeline until ack or timeout.
//
// Handshake: an access is offered while valid & (mem_read|mem_write); the
// upstream keeps it stable while stall=1 and treats stall=0 as "consumed".
// On the bus, mreq is high for every BUSY cycle; the memory answers with a
// one-cycle ack (rd_data valid with it). ack outside BUSY has no effect.
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    output logic              stall,
    output logic [31:0]       read_data,
    output logic              resp_valid,
    output logic              misaligned,
    output logic              fault,
    mem_stage_hs_if.master    bus
);
    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              is_write_q, is_write_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic              misaligned_q, misaligned_d;
    logic              fault_q, fault_d;

    logic        busy;
    logic        start;
    logic        ok;
    logic        legal;
    logic        aligned;
    logic [3:0]  req_be;
    logic [31:0] req_wr_data;
    logic [31:0] load_data;

    mem_lane_align u_align (
        .req_funct3    (funct3),
        .req_is_write  (mem_write),
        .req_off       (address[1:0]),
        .req_wdata     (write_data),
        .req_legal     (legal),
        .req_aligned   (aligned),
        .req_be        (req_be),
        .req_wr_data   (req_wr_data),
        .rsp_funct3    (f3_q),
        .rsp_off       (off_q),
        .rsp_rdata     (bus.rd_data),
        .rsp_load_data (load_data)
    );

    assign busy  = (state_q == BUSY);
    assign start = (state_q == IDLE) & valid & (mem_read | mem_write);
    assign ok    = start & legal & aligned;

    // Next-state and next-output computation for the access FSM
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        f3_d         = f3_q;
        off_d        = off_q;
        is_write_d   = is_write_q;
        read_data_d  = read_data_q;
        resp_valid_d = 1'b0;
        misaligned_d = 1'b0;
        fault_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ok) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    addr_d     = {address[ADDR_W-1:2], 2'b00};
                    be_d       = req_be;
                    wdata_d    = mem_write ? req_wr_data : 32'h0;
                    f3_d       = funct3;
                    off_d      = address[1:0];
                    is_write_d = mem_write;
                end else if (start) begin
                    misaligned_d = 1'b1;
                end
            end
            BUSY: begin
                if (bus.ack) begin
                    // stores complete without touching the load result
                    if (!is_write_q) begin
                        read_data_d = load_data;
                    end
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All stage state; reset drops any in-flight request without response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            is_write_q   <= 1'b0;
            read_data_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            is_write_q   <= is_write_d;
            read_data_q  <= read_data_d;
            resp_valid_q <= resp_valid_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
        end
    end

    // Hold upstream while accepting, and while waiting unless this is the
    // last permitted cycle (the stage then frees itself via fault).
    assign stall = ok | (busy & ~bus.ack & (cnt_q != CNT_LAST));

    assign read_data  = read_data_q;
    assign resp_valid = resp_valid_q;
    assign misaligned = misaligned_q;
    assign fault      = fault_q;

    assign bus.mreq    = busy;
    assign bus.write   = busy & is_write_q;
    assign bus.byte_en = busy ? be_q : 4'b0000;
    assign bus.wr_data = (busy & is_write_q) ? wdata_q : 32'h0;
    assign bus.addr    = busy ? addr_q : '0;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Testbench for mem_stage_hs: scenario tasks drive accesses and play the
// memory; responses are matched against an expected queue.
module tb_mem_stage_hs;
    import mem_stage_pkg::*;

    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        valid;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        stall;
    logic [31:0] read_data;
    logic        resp_valid;
    logic        misaligned;
    logic        fault;

    mem_stage_hs_if #(.ADDR_W(32)) bus ();

    mem_stage_hs #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .stall      (stall),
        .read_data  (read_data),
        .resp_valid (resp_valid),
        .misaligned (misaligned),
        .fault      (fault),
        .bus        (bus)
    );

    // ---------------- scoreboard ----------------
    // entry = {fault, misaligned, resp_valid, read_data}
    logic [34:0] exp_q[$];
    logic [34:0] exp_e;
    logic [31:0] model_rd;
    int errors = 0;
    int checks = 0;

    // observations from the last drive_access
    int          obs_stall;
    int          obs_busy;
    int          obs_wcyc;
    int          obs_pulse_cyc;
    logic        obs_got;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd;
    logic [34:0] obs_resp;

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_W:    return w;
            F3_BU:   return {24'h0, b};
            F3_HU:   return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Offers one access, holds it while stall=1, acks on BUSY cycle ack_at
    // (negative = never), returns after the first response pulse.
    task automatic drive_access(input logic is_wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rword, input int ack_at);
        logic prev_stall;
        int   cyc;
        obs_stall = 0; obs_busy = 0; obs_wcyc = 0; obs_pulse_cyc = -1;
        obs_got = 1'b0; obs_addr = 32'h0; obs_be = 4'h0; obs_wd = 32'h0;
        obs_resp = 35'h0;
        @(negedge clk);
        valid = 1'b1; mem_write = is_wr; mem_read = ~is_wr;
        funct3 = f3; address = a; write_data = wd;
        prev_stall = 1'b1;
        cyc = 0;
        while (!obs_got && cyc < 60) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (!prev_stall) begin
                    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
                end
            end
            bus.ack = 1'b0;
            bus.rd_data = 32'h0;
            if (bus.mreq) begin
                if (obs_busy == 0) begin
                    obs_addr = bus.addr; obs_be = bus.byte_en; obs_wd = bus.wr_data;
                end
                if (bus.write) obs_wcyc++;
                if (obs_busy == ack_at) begin
                    bus.ack = 1'b1; bus.rd_data = rword;
                end
                obs_busy++;
            end
            #1;
            if (stall) obs_stall++;
            prev_stall = stall;
            if (resp_valid | misaligned | fault) begin
                obs_got = 1'b1;
                obs_resp = {fault, misaligned, resp_valid, read_data};
                obs_pulse_cyc = cyc;
            end
            cyc++;
        end
        bus.ack = 1'b0;
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0; address = 32'h0; write_data = 32'h0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        bus.ack = 1'b0; bus.rd_data = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({stall, read_data, resp_valid, misaligned, fault, bus.mreq, bus.write,
             bus.byte_en, bus.wr_data, bus.addr} !== 104'h0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b rd=%h rv=%b mis=%b flt=%b mreq=%b wr=%b be=%b wd=%h addr=%h, need all 0",
                     stall, read_data, resp_valid, misaligned, fault, bus.mreq, bus.write,
                     bus.byte_en, bus.wr_data, bus.addr);
        end
        checks++;
        if (bus.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d need IDLE", bus.state);
        end
        model_rd = 32'h0;
    endtask

    task automatic test_store_word();
        exp_q.push_back({3'b001, model_rd});
        drive_access(1'b1, F3_W, 32'h104, 32'hDEADBEEF, 32'h0, 0);
        checks++;
        if ({obs_addr, obs_be, obs_wd} !== {32'h104, 4'b1111, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL sw_bus: got addr=%h be=%b wd=%h need 104 1111 deadbeef", obs_addr, obs_be, obs_wd);
        end
        checks++;
        if (obs_wcyc !== 1 || obs_stall !== 1 || obs_pulse_cyc !== 2) begin
            errors++;
            $display("FAIL sw_timing: got write_cycles=%0d stall=%0d resp_at=%0d need 1 1 2",
                     obs_wcyc, obs_stall, obs_pulse_cyc);
        end
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
        checks++;
        if (obs_resp !== exp_e) begin
            errors++;
            $display("FAIL sw_resp: got %h need %h", obs_resp, exp_e);
        end
    endtask

    task automatic test_store_steer();
        logic [2:0]  t_f3[3]  = '{F3_B, F3_H, F3_B};
        logic [31:0] t_a[3]   = '{32'h103, 32'h102, 32'h100};
        logic [31:0] t_wd[3]  = '{32'h000000A5, 32'h1234BEEF, 32'hFFFFFF3C};
        logic [3:0]  t_be[3]  = '{4'b1000, 4'b1100, 4'b0001};
        logic [31:0] t_ewd[3] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h3C3C3C3C};
        int          t_ack[3] = '{0, 1, 2};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({3'b001, model_rd});
            drive_access(1'b1, t_f3[i], t_a[i], t_wd[i], 32'hFFFFFFFF, t_ack[i]);
            checks++;
            if ({obs_addr, obs_be, obs_wd} !== {32'h100, t_be[i], t_ewd[i]}) begin
                errors++;
                $display("FAIL store_steer[%0d]: got addr=%h be=%b wd=%h need 100 %b %h",
                         i, obs_addr, obs_be, obs_wd, t_be[i], t_ewd[i]);
            end
            checks++;
            if (obs_stall !== t_ack[i] + 1 || obs_pulse_cyc !== t_ack[i] + 2) begin
                errors++;
                $display("FAIL store_latency[%0d]: got stall=%0d resp_at=%0d need %0d %0d",
                         i, obs_stall, obs_pulse_cyc, t_ack[i] + 1, t_ack[i] + 2);
            end
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            checks++;
            if (obs_resp !== exp_e) begin
                errors++;
                $display("FAIL store_resp[%0d]: got %h need %h", i, obs_resp, exp_e);
            end
        end
    endtask

    task automatic test_loads();
        logic [2:0]  t_f3[6]  = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B};
        logic [31:0] t_a[6]   = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h100, 32'h103};
        logic [31:0] t_rw[6]  = '{32'h00008000, 32'h00008000, 32'h80010000, 32'h80010000,
                                  32'h12345678, 32'h7F000000};
        logic [31:0] t_exp[6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                  32'h12345678, 32'h0000007F};
        logic [3:0]  t_be[6]  = '{4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b1111, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            model_rd = t_exp[i];
            exp_q.push_back({3'b001, model_rd});
            drive_access(1'b0, t_f3[i], t_a[i], 32'hCAFEF00D, t_rw[i], i % 2);
            checks++;
            if ({obs_addr, obs_be, obs_wd, obs_wcyc} !== {32'h100, t_be[i], 32'h0, 32'd0}) begin
                errors++;
                $display("FAIL load_bus[%0d]: got addr=%h be=%b wd=%h wcyc=%0d need 100 %b 0 0",
                         i, obs_addr, obs_be, obs_wd, obs_wcyc, t_be[i]);
            end
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            checks++;
            if (obs_resp !== exp_e) begin
                errors++;
                $display("FAIL load_resp[%0d]: got %h need %h", i, obs_resp, exp_e);
            end
        end
    endtask

    task automatic test_random_loads();
        logic [2:0]  f3s[5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] w;
        logic [31:0] a;
        for (int i = 0; i < 10; i++) begin
            f3  = f3s[$urandom_range(0, 4)];
            off = 2'($urandom_range(0, 3));
            if (f3 == F3_H || f3 == F3_HU) off[0] = 1'b0;
            if (f3 == F3_W) off = 2'b00;
            w = $urandom;
            a = {20'h0, 10'($urandom_range(0, 1023)), off};
            model_rd = model_load(f3, off, w);
            exp_q.push_back({3'b001, model_rd});
            drive_access(1'b0, f3, a, 32'h0, w, $urandom_range(0, 3));
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            checks++;
            if (obs_resp !== exp_e || obs_addr !== {a[31:2], 2'b00}) begin
                errors++;
                $display("FAIL rand_load[%0d] f3=%b off=%0d: got resp=%h addr=%h need %h %h",
                         i, f3, off, obs_resp, obs_addr, exp_e, {a[31:2], 2'b00});
            end
        end
    endtask

    task automatic test_misaligned();
        logic        t_wr[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  t_f3[9] = '{F3_W, F3_H, F3_HU, F3_W, F3_H, 3'b011, F3_BU, 3'b110, 3'b111};
        logic [31:0] t_a[9]  = '{32'h102, 32'h101, 32'h103, 32'h101, 32'h103,
                                 32'h100, 32'h100, 32'h100, 32'h104};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({3'b010, model_rd});
            drive_access(t_wr[i], t_f3[i], t_a[i], 32'h55AA55AA, 32'h0, 0);
            checks++;
            if (obs_busy !== 0 || obs_stall !== 0 || obs_pulse_cyc !== 1) begin
                errors++;
                $display("FAIL reject[%0d]: got mreq_cycles=%0d stall=%0d pulse_at=%0d need 0 0 1",
                         i, obs_busy, obs_stall, obs_pulse_cyc);
            end
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            checks++;
            if (obs_resp !== exp_e) begin
                errors++;
                $display("FAIL reject_resp[%0d]: got %h need %h", i, obs_resp, exp_e);
            end
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back({3'b100, model_rd});
        drive_access(1'b0, F3_W, 32'h200, 32'h0, 32'h0, -1);
        checks++;
        if (obs_stall !== TIMEOUT || obs_busy !== TIMEOUT || obs_pulse_cyc !== TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_timing: got stall=%0d busy=%0d fault_at=%0d need %0d %0d %0d",
                     obs_stall, obs_busy, obs_pulse_cyc, TIMEOUT, TIMEOUT, TIMEOUT + 1);
        end
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
        checks++;
        if (obs_resp !== exp_e) begin
            errors++;
            $display("FAIL timeout_resp: got %h need %h", obs_resp, exp_e);
        end
        checks++;
        if (bus.mreq !== 1'b0 || bus.state !== IDLE) begin
            errors++;
            $display("FAIL timeout_idle: got mreq=%b state=%0d need 0 IDLE", bus.mreq, bus.state);
        end
    endtask

    task automatic test_back_to_back();
        // first load: LW 0x300
        @(negedge clk);
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; address = 32'h300;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_a: got stall=%b need 1", stall);
        end
        @(negedge clk);
        bus.ack = 1'b1; bus.rd_data = 32'h11112222;
        model_rd = 32'h11112222;
        exp_q.push_back({3'b001, model_rd});
        #1;
        checks++;
        if (stall !== 1'b0 || bus.mreq !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ack_a: got stall=%b mreq=%b need 0 1", stall, bus.mreq);
        end
        // second load offered right after the ack cycle: LBU 0x305
        @(negedge clk);
        bus.ack = 1'b0; bus.rd_data = 32'h0;
        funct3 = F3_BU; address = 32'h305;
        #1;
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
        checks++;
        if (stall !== 1'b1 || {fault, misaligned, resp_valid, read_data} !== exp_e) begin
            errors++;
            $display("FAIL b2b_resp_a: got stall=%b resp=%h need 1 %h", stall,
                     {fault, misaligned, resp_valid, read_data}, exp_e);
        end
        @(negedge clk);
        bus.ack = 1'b1; bus.rd_data = 32'h0000AB00;
        model_rd = 32'h000000AB;
        exp_q.push_back({3'b001, model_rd});
        #1;
        checks++;
        if (bus.mreq !== 1'b1 || bus.addr !== 32'h304 || bus.byte_en !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_bus_b: got mreq=%b addr=%h be=%b need 1 304 0010",
                     bus.mreq, bus.addr, bus.byte_en);
        end
        @(negedge clk);
        bus.ack = 1'b0; valid = 1'b0; mem_read = 1'b0;
        #1;
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
        checks++;
        if ({fault, misaligned, resp_valid, read_data} !== exp_e) begin
            errors++;
            $display("FAIL b2b_resp_b: got %h need %h", {fault, misaligned, resp_valid, read_data}, exp_e);
        end
    endtask

    task automatic test_ignore();
        logic any_bad;
        // valid low with a load, then valid high with no op
        @(negedge clk);
        valid = 1'b0; mem_read = 1'b1; funct3 = F3_W; address = 32'h100;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_novalid: got stall=%b need 0", stall);
        end
        @(negedge clk);
        valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_noop: got stall=%b need 0", stall);
        end
        // stray acks while IDLE
        any_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid = 1'b0;
            bus.ack = 1'b1; bus.rd_data = $urandom;
            #1;
            if (resp_valid | misaligned | fault | bus.mreq | stall | (read_data !== model_rd))
                any_bad = 1'b1;
        end
        @(negedge clk);
        bus.ack = 1'b0;
        #1;
        if (resp_valid | misaligned | fault | (read_data !== model_rd)) any_bad = 1'b1;
        checks++;
        if (any_bad !== 1'b0) begin
            errors++;
            $display("FAIL idle_stray_ack: got activity or read_data=%h need quiet and %h",
                     read_data, model_rd);
        end
    endtask

    task automatic test_reset_busy();
        logic any_resp;
        @(negedge clk);
        valid = 1'b1; mem_read = 1'b1; funct3 = F3_W; address = 32'h400;
        @(negedge clk);
        #1;
        checks++;
        if (bus.mreq !== 1'b1) begin
            errors++;
            $display("FAIL rstb_busy: got mreq=%b need 1", bus.mreq);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mreq !== 1'b0 || bus.write !== 1'b0 || bus.byte_en !== 4'b0) begin
            errors++;
            $display("FAIL rstb_drop: got mreq=%b write=%b be=%b need 0 0 0",
                     bus.mreq, bus.write, bus.byte_en);
        end
        valid = 1'b0; mem_read = 1'b0;
        model_rd = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        any_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.ack = (i == 1);
            bus.rd_data = 32'hFFFFFFFF;
            #1;
            if (resp_valid | fault | misaligned) any_resp = 1'b1;
        end
        bus.ack = 1'b0;
        checks++;
        if (any_resp !== 1'b0 || read_data !== model_rd) begin
            errors++;
            $display("FAIL rstb_quiet: got pulse=%b read_data=%h need 0 %h", any_resp, read_data, model_rd);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_store_word();
        test_store_steer();
        test_loads();
        test_random_loads();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_ignore();
        test_reset_busy();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
